// File: rtl/irig_b_tx.sv
// IRIG-B (B00x, DC level-shift) time-code generator: one 100-bit BCD frame per second on irig_out.
// Define IRIG_B_TX_SBS_EN to carry straight-binary seconds-of-day in bits 80-97.
module irig_b_tx #(
  parameter int TICKS_PER_MS = 100000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic        leap_year,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [6:0]  load_sec,
  input  logic [6:0]  load_min,
  input  logic [5:0]  load_hour,
  input  logic [9:0]  load_day,
  input  logic [7:0]  load_year,
  output logic        irig_out,
  output logic        frame_start,
  output logic        busy,
  output logic [37:0] cur_time
);

  localparam int TW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_MS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [7:0] year;
    logic [9:0] day;
    logic [5:0] hour;
    logic [6:0] min;
    logic [6:0] sec;
  } bcd_time_t;

  localparam bcd_time_t TIME_RST = '{year: 8'h00, day: 10'h001, hour: 6'h00, min: 7'h00, sec: 7'h00};

  function automatic logic [99:0] mark_map();
    logic [99:0] m;
    m = '0;
    m[0] = 1'b1;
    for (int i = 9; i < 100; i += 10) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [99:0] MARKS = mark_map();

  // three-digit BCD +1; digits beyond 9 give undefined but harmless results
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      if (v[7:4] == 4'd9) begin
        r[7:4]  = 4'd0;
        r[11:8] = v[11:8] + 4'd1;
      end else begin
        r[7:4] = v[7:4] + 4'd1;
      end
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [3:0]      ms_q, ms_d;
  logic [6:0]      bit_q, bit_d;
  bcd_time_t       time_q, time_d, pend_val_q, pend_val_d, time_inc;
  logic            pend_q, pend_d, ready_q, ready_d;
  logic            accept, apply, boundary, tick_end;
  logic            sec_wrap, min_wrap, hour_wrap, day_wrap;
  logic [99:0]     frame_bits;
  logic [3:0]      hi_ms;

  assign tick_end = (tick_q == TICK_LAST);
  assign boundary = (state_q == RUN) && tick_end && (ms_q == 4'd9) && (bit_q == 7'd99);
  assign accept   = load_valid && ready_q;
  // a load taken on the boundary cycle only becomes pending after it, so that boundary increments
  assign apply    = pend_q && ((state_q == IDLE) || boundary);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (boundary && !enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    irig_out    = 1'b0;
    frame_start = 1'b0;
    busy        = 1'b0;
    if (state_q == RUN) begin
      busy        = 1'b1;
      irig_out    = (ms_q < hi_ms);
      frame_start = (bit_q == 7'd0) && (ms_q == 4'd0) && (tick_q == '0);
    end
  end

  always_comb begin
    tick_d = tick_q;
    ms_d   = ms_q;
    bit_d  = bit_q;
    if (state_q == RUN) begin
      if (tick_end) begin
        tick_d = '0;
        if (ms_q == 4'd9) begin
          ms_d  = 4'd0;
          bit_d = (bit_q == 7'd99) ? 7'd0 : bit_q + 7'd1;
        end else begin
          ms_d = ms_q + 4'd1;
        end
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  always_comb begin
    sec_wrap  = (time_q.sec  == 7'h59);
    min_wrap  = (time_q.min  == 7'h59);
    hour_wrap = (time_q.hour == 6'h23);
    day_wrap  = (time_q.day  == (leap_year ? 10'h366 : 10'h365));
    time_inc  = time_q;
    time_inc.sec = sec_wrap ? 7'h00 : 7'(bcd_inc({5'd0, time_q.sec}));
    if (sec_wrap)
      time_inc.min = min_wrap ? 7'h00 : 7'(bcd_inc({5'd0, time_q.min}));
    if (sec_wrap && min_wrap)
      time_inc.hour = hour_wrap ? 6'h00 : 6'(bcd_inc({6'd0, time_q.hour}));
    if (sec_wrap && min_wrap && hour_wrap)
      time_inc.day = day_wrap ? 10'h001 : 10'(bcd_inc({2'd0, time_q.day}));
    if (sec_wrap && min_wrap && hour_wrap && day_wrap)
      time_inc.year = (time_q.year == 8'h99) ? 8'h00 : 8'(bcd_inc({4'd0, time_q.year}));
  end

  always_comb begin
    time_d     = time_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    if (apply)         time_d = pend_val_q;
    else if (boundary) time_d = time_inc;
    if (apply) pend_d = 1'b0;
    if (accept) begin
      pend_d     = 1'b1;
      pend_val_d = '{year: load_year, day: load_day, hour: load_hour, min: load_min, sec: load_sec};
    end
    ready_d = !pend_d;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tick_q     <= '0;
      ms_q       <= 4'd0;
      bit_q      <= 7'd0;
      time_q     <= TIME_RST;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      ms_q       <= ms_d;
      bit_q      <= bit_d;
      time_q     <= time_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      ready_q    <= ready_d;
    end
  end

`ifdef IRIG_B_TX_SBS_EN
  function automatic logic [16:0] bcd2bin(input logic [7:0] v);
    return 17'(v[7:4]) * 17'd10 + 17'(v[3:0]);
  endfunction

  logic [16:0] sbs_q, sbs_d, sbs_load;

  always_comb begin
    sbs_load = bcd2bin({1'b0, pend_val_q.sec})
             + bcd2bin({1'b0, pend_val_q.min}) * 17'd60
             + bcd2bin({2'b0, pend_val_q.hour}) * 17'd3600;
    sbs_d = sbs_q;
    if (apply)
      sbs_d = sbs_load;
    else if (boundary)
      sbs_d = (sec_wrap && min_wrap && hour_wrap) ? 17'd0 : sbs_q + 17'd1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) sbs_q <= 17'd0;
    else          sbs_q <= sbs_d;
  end
`endif

  // frame bit map, LSB of each field first; markers handled separately
  always_comb begin
    frame_bits        = '0;
    frame_bits[4:1]   = time_q.sec[3:0];
    frame_bits[8:6]   = time_q.sec[6:4];
    frame_bits[13:10] = time_q.min[3:0];
    frame_bits[17:15] = time_q.min[6:4];
    frame_bits[23:20] = time_q.hour[3:0];
    frame_bits[26:25] = time_q.hour[5:4];
    frame_bits[33:30] = time_q.day[3:0];
    frame_bits[38:35] = time_q.day[7:4];
    frame_bits[41:40] = time_q.day[9:8];
    frame_bits[53:50] = time_q.year[3:0];
    frame_bits[58:55] = time_q.year[7:4];
`ifdef IRIG_B_TX_SBS_EN
    frame_bits[88:80] = sbs_q[8:0];
    frame_bits[97:90] = sbs_q[16:9];
`endif
    hi_ms = MARKS[bit_q] ? 4'd8 : (frame_bits[bit_q] ? 4'd5 : 4'd2);
  end

  assign load_ready = ready_q;
  assign cur_time   = time_q;

endmodule

// File: tb/tb_irig_b_tx.sv
// Bench for irig_b_tx: second-level time model plus frame-position model checked every cycle,
// with directed scenarios (load, rollover, enable drop, load/boundary collision, async reset).
module tb_irig_b_tx;

  localparam int T   = 10;
  localparam int BIT = 10 * T;
  localparam int FR  = 100 * BIT;

  logic        aclk = 1'b0, aresetn = 1'b0, enable = 1'b0, leap_year = 1'b0, load_valid = 1'b0;
  logic        load_ready, irig_out, frame_start, busy;
  logic [6:0]  load_sec = '0, load_min = '0;
  logic [5:0]  load_hour = '0;
  logic [9:0]  load_day = '0;
  logic [7:0]  load_year = '0;
  logic [37:0] cur_time;

  irig_b_tx #(.TICKS_PER_MS(T)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .leap_year(leap_year),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_sec(load_sec), .load_min(load_min), .load_hour(load_hour),
    .load_day(load_day), .load_year(load_year),
    .irig_out(irig_out), .frame_start(frame_start), .busy(busy), .cur_time(cur_time)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int nchk = 0, nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // model: time as plain integers, frame position as cycles since on-time point
  bit m_run = 0, m_pend = 0, m_ready = 0;
  int m_pos = 0;
  int m_s = 0, m_m = 0, m_h = 0, m_d = 1, m_y = 0;
  int p_s = 0, p_m = 0, p_h = 0, p_d = 0, p_y = 0;

  function automatic int dec(input logic [11:0] v);
    return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [37:0] exp_time();
    logic [7:0] y;
    logic [9:0] d;
    logic [5:0] h;
    logic [6:0] mi, s;
    y  = {4'(m_y / 10), 4'(m_y % 10)};
    d  = {2'(m_d / 100), 4'((m_d / 10) % 10), 4'(m_d % 10)};
    h  = {2'(m_h / 10), 4'(m_h % 10)};
    mi = {3'(m_m / 10), 4'(m_m % 10)};
    s  = {3'(m_s / 10), 4'(m_s % 10)};
    return {y, d, h, mi, s};
  endfunction

  function automatic bit fld(input int val, input int b, input int lo, input int hi);
    return (b >= lo && b <= hi) ? (((val >> (b - lo)) & 1) == 1) : 1'b0;
  endfunction

  function automatic int exp_hi(input int b);
    bit v;
    if (b == 0 || b % 10 == 9) return 8;
    v = fld(m_s % 10, b, 1, 4) | fld(m_s / 10, b, 6, 8)
      | fld(m_m % 10, b, 10, 13) | fld(m_m / 10, b, 15, 17)
      | fld(m_h % 10, b, 20, 23) | fld(m_h / 10, b, 25, 26)
      | fld(m_d % 10, b, 30, 33) | fld((m_d / 10) % 10, b, 35, 38) | fld(m_d / 100, b, 40, 41)
      | fld(m_y % 10, b, 50, 53) | fld(m_y / 10, b, 55, 58);
`ifdef IRIG_B_TX_SBS_EN
    begin
      int sbs;
      sbs = m_s + 60 * m_m + 3600 * m_h;
      v = v | fld(sbs, b, 80, 88) | fld(sbs >> 9, b, 90, 97);
    end
`endif
    return v ? 5 : 2;
  endfunction

  task automatic next_second();
    m_s++;
    if (m_s == 60) begin
      m_s = 0; m_m++;
      if (m_m == 60) begin
        m_m = 0; m_h++;
        if (m_h == 24) begin
          m_h = 0; m_d++;
          if (m_d > (leap_year ? 366 : 365)) begin
            m_d = 1; m_y = (m_y + 1) % 100;
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge aclk);
    if (!aresetn) begin
      m_run = 0; m_pend = 0; m_ready = 0; m_pos = 0;
      m_s = 0; m_m = 0; m_h = 0; m_d = 1; m_y = 0;
    end else begin
      bit acc, bnd, app;
      acc = load_valid && m_ready;
      bnd = m_run && (m_pos == FR - 1);
      app = m_pend && (!m_run || bnd);
      if (app) begin
        m_s = p_s; m_m = p_m; m_h = p_h; m_d = p_d; m_y = p_y;
      end else if (bnd) begin
        next_second();
      end
      if (app) m_pend = 0;
      if (acc) begin
        m_pend = 1;
        p_s = dec({5'd0, load_sec}); p_m = dec({5'd0, load_min}); p_h = dec({6'd0, load_hour});
        p_d = dec({2'd0, load_day}); p_y = dec({4'd0, load_year});
      end
      m_ready = !m_pend;
      if (!m_run) begin
        if (enable) begin m_run = 1; m_pos = 0; end
      end else if (bnd) begin
        m_run = enable; m_pos = 0;
      end else begin
        m_pos++;
      end
    end
  end

  initial forever begin
    @(negedge aclk);
    if (aresetn) begin
      bit e_out;
      e_out = m_run && ((m_pos % BIT) < exp_hi(m_pos / BIT) * T);
      chk("irig_out", 64'(irig_out), 64'(e_out));
      chk("busy", 64'(busy), 64'(m_run));
      chk("frame_start", 64'(frame_start), 64'(m_run && m_pos == 0));
      chk("load_ready", 64'(load_ready), 64'(m_ready));
      chk("cur_time", 64'(cur_time), 64'(exp_time()));
    end
  end

  task automatic do_load(input logic [6:0] s, input logic [6:0] mi, input logic [5:0] h,
                         input logic [9:0] d, input logic [7:0] y);
    bit done;
    done = 0;
    load_sec = s; load_min = mi; load_hour = h; load_day = d; load_year = y;
    load_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge aclk);
      done = load_ready;
      @(posedge aclk);
      #2;
    end
    load_valid = 1'b0;
    chk("load_accept", 64'(done), 64'd1);
  endtask

  // call from a negedge; returns at the negedge where frame_start is seen
  task automatic wait_fs(input int bound, output int at, output bit ok);
    ok = 0; at = 0;
    for (int k = 0; k < bound && !ok; k++) begin
      if (frame_start) begin ok = 1; at = cyc; end
      else @(negedge aclk);
    end
  endtask

  task automatic count_high(input int n, output int h);
    h = 0;
    repeat (n) begin
      if (irig_out) h++;
      @(negedge aclk);
    end
  endtask

  initial begin
    int w0, w1, w2, w80, fs1, fs2, fs3, fs4, fs5, nfs, k;
    bit ok;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_irig_out", 64'(irig_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_start", 64'(frame_start), 64'd0);
    chk("rst_load_ready", 64'(load_ready), 64'd0);
    @(posedge aclk); #2 aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    chk("ready_after_rst", 64'(load_ready), 64'd1);
    chk("time_after_rst", 64'(cur_time), 64'({8'h00, 10'h001, 6'h00, 7'h00, 7'h00}));

    do_load(7'h59, 7'h59, 6'h23, 10'h365, 8'h24);
    repeat (4) @(negedge aclk);
    chk("time_loaded_idle", 64'(cur_time), 64'({8'h24, 10'h365, 6'h23, 7'h59, 7'h59}));
    chk("idle_busy", 64'(busy), 64'd0);

    @(posedge aclk); #2 enable = 1'b1;
    @(negedge aclk);
    wait_fs(20, fs1, ok);
    chk("fs1_seen", 64'(ok), 64'd1);
    chk("f1_time", 64'(cur_time), 64'({8'h24, 10'h365, 6'h23, 7'h59, 7'h59}));
    count_high(BIT, w0); chk("width_bit0_marker", 64'(w0), 64'd80);
    count_high(BIT, w1); chk("width_bit1_one", 64'(w1), 64'd50);
    count_high(BIT, w2); chk("width_bit2_zero", 64'(w2), 64'd20);
    wait_fs(FR + 10, fs2, ok);
    chk("fs2_seen", 64'(ok), 64'd1);
    chk("frame_len", 64'(fs2 - fs1), 64'(FR));
    chk("f2_time_rollover", 64'(cur_time), 64'({8'h25, 10'h001, 6'h00, 7'h00, 7'h00}));

    // drop enable at bit 40: frame must still run to bit 99
    repeat (40 * BIT) @(posedge aclk);
    #2 enable = 1'b0;
    @(negedge aclk);
    for (k = 0; k < FR && busy; k++) @(negedge aclk);
    chk("idle_at_frame_end", 64'(cyc - fs2), 64'(FR));
    nfs = 0;
    repeat (300) begin
      if (frame_start) nfs++;
      @(negedge aclk);
    end
    chk("no_fs_when_idle", 64'(nfs), 64'd0);
    chk("idle_busy2", 64'(busy), 64'd0);

    // load arriving on the last cycle of a frame lands one frame later
    @(posedge aclk); #2 enable = 1'b1;
    @(negedge aclk);
    wait_fs(20, fs3, ok);
    chk("fs3_seen", 64'(ok), 64'd1);
    chk("f3_time", 64'(cur_time), 64'({8'h25, 10'h001, 6'h00, 7'h00, 7'h01}));
    repeat (FR - 1) @(posedge aclk);
    #2;
    load_sec = 7'h05; load_min = 7'h00; load_hour = 6'h01; load_day = 10'h100; load_year = 8'h30;
    load_valid = 1'b1;
    @(posedge aclk); #2 load_valid = 1'b0;
    @(negedge aclk);
    chk("f4_start", 64'(frame_start), 64'd1);
    fs4 = cyc;
    chk("f4_time_increment", 64'(cur_time), 64'({8'h25, 10'h001, 6'h00, 7'h00, 7'h02}));
    chk("ready_while_pending", 64'(load_ready), 64'd0);
    @(negedge aclk);
    wait_fs(FR + 10, fs5, ok);
    chk("fs5_seen", 64'(ok), 64'd1);
    chk("f4_len", 64'(fs5 - fs4), 64'(FR));
    chk("f5_time_loaded", 64'(cur_time), 64'({8'h30, 10'h100, 6'h01, 7'h00, 7'h05}));

    repeat (80 * BIT) @(negedge aclk);
    count_high(BIT, w80);
`ifdef IRIG_B_TX_SBS_EN
    chk("width_bit80_sbs", 64'(w80), 64'd50);
`else
    chk("width_bit80_sbs", 64'(w80), 64'd20);
`endif

    // async reset mid-bit while the line is high
    chk("pre_rst_high", 64'(irig_out), 64'd1);
    #1 aresetn = 1'b0;
    #1;
    chk("async_rst_irig_out", 64'(irig_out), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_ready", 64'(load_ready), 64'd0);
    chk("async_rst_time", 64'(cur_time), 64'({8'h00, 10'h001, 6'h00, 7'h00, 7'h00}));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
